// File: rtl/hex_page_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_page_ctrl
//  Description : Shares one hex-to-7-segment converter across four registered
//                HEX digits. Shows a 32-bit word, loaded by a req/ack
//                handshake, as two 16-bit pages alternating on a timer.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_page_ctrl #(
    parameter int PAGE_CYCLES = 50000000,
    parameter int TIMER_W     = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        loadReq,
    input  logic [31:0] loadData,
    output logic        loadAck,
    input  logic        holdPage,
    input  logic        blank,
    output logic [3:0]  nibOut,
    input  logic [6:0]  segIn,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic        pageIdx,
    output logic        busy
);

    localparam logic [0:0]         C_ST_IDLE    = 1'b0;
    localparam logic [0:0]         C_ST_SWEEP   = 1'b1;
    localparam logic [TIMER_W-1:0] C_TIMER_LAST = TIMER_W'(PAGE_CYCLES - 1);
    localparam logic [6:0]         C_SEG_OFF    = 7'b1111111;

    logic [0:0]         state_q, state_d;
    logic [1:0]         digit_q, digit_d;
    logic [31:0]        word_q, word_d;
    logic               page_q, page_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               ack_q, ack_d;
    logic [3:0][6:0]    hex_q, hex_d;

    // State register: reset starts a sweep of the cleared word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_ST_SWEEP;
            digit_q <= 2'd0;
            word_q  <= 32'd0;
            page_q  <= 1'b0;
            timer_q <= '0;
            ack_q   <= 1'b0;
            hex_q   <= {4{C_SEG_OFF}};
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            word_q  <= word_d;
            page_q  <= page_d;
            timer_q <= timer_d;
            ack_q   <= ack_d;
            hex_q   <= hex_d;
        end
    end

    // Next-state logic: sweep one digit per cycle, then idle/load/page timer
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        word_d  = word_q;
        page_d  = page_q;
        timer_d = timer_q;
        ack_d   = 1'b0;
        hex_d   = hex_q;
        case (state_q)
            C_ST_SWEEP: begin
                // Timer is frozen and requests are ignored while sweeping
                hex_d[digit_q] = segIn;
                digit_d        = digit_q + 2'd1;
                if (digit_q == 2'd3) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                if (loadReq) begin
                    // A load beats a coinciding page flip
                    word_d  = loadData;
                    page_d  = 1'b0;
                    timer_d = '0;
                    ack_d   = 1'b1;
                    state_d = C_ST_SWEEP;
                end else if (!holdPage) begin
                    if (timer_q == C_TIMER_LAST) begin
                        timer_d = '0;
                        page_d  = ~page_q;
                        state_d = C_ST_SWEEP;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
        endcase
    end

    // Outputs: converter nibble select, status, blanking overlay
    always_comb begin
        nibOut  = 4'd0;
        busy    = 1'b0;
        if (state_q == C_ST_SWEEP) begin
            nibOut = word_q[{page_q, digit_q, 2'b00} +: 4];
            busy   = 1'b1;
        end
        loadAck = ack_q;
        pageIdx = page_q;
        hex0    = blank ? C_SEG_OFF : hex_q[0];
        hex1    = blank ? C_SEG_OFF : hex_q[1];
        hex2    = blank ? C_SEG_OFF : hex_q[2];
        hex3    = blank ? C_SEG_OFF : hex_q[3];
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_page_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_page_ctrl
//  Description : Directed self-checking bench for hex_page_ctrl with an
//                attached active-low hex-to-7-segment converter model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_page_ctrl;

    logic        clk;
    logic        rst;
    logic        loadReq;
    logic [31:0] loadData;
    logic        loadAck;
    logic        holdPage;
    logic        blank;
    logic [3:0]  nibOut;
    logic [6:0]  segIn;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        pageIdx;
    logic        busy;

    int n_checks;
    int n_errors;

    localparam logic [6:0] C_OFF = 7'b1111111;
    localparam logic [6:0] C_S0  = 7'b1000000;
    localparam logic [6:0] C_S1  = 7'b1111001;
    localparam logic [6:0] C_S2  = 7'b0100100;
    localparam logic [6:0] C_S3  = 7'b0110000;
    localparam logic [6:0] C_S4  = 7'b0011001;
    localparam logic [6:0] C_S7  = 7'b1111000;
    localparam logic [6:0] C_S8  = 7'b0000000;
    localparam logic [6:0] C_S9  = 7'b0010000;
    localparam logic [6:0] C_SA  = 7'b0001000;
    localparam logic [6:0] C_SB  = 7'b0000011;
    localparam logic [6:0] C_SC  = 7'b0100111;
    localparam logic [6:0] C_SD  = 7'b0100001;
    localparam logic [6:0] C_SF  = 7'b0001110;

    hex_page_ctrl #(
        .PAGE_CYCLES(8),
        .TIMER_W    (4)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .loadReq (loadReq),
        .loadData(loadData),
        .loadAck (loadAck),
        .holdPage(holdPage),
        .blank   (blank),
        .nibOut  (nibOut),
        .segIn   (segIn),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .pageIdx (pageIdx),
        .busy    (busy)
    );

    // Shared converter model (active-low, lowercase b/c/d)
    function automatic logic [6:0] seg_lut(input logic [3:0] n);
        case (n)
            4'h0: seg_lut = 7'b1000000;
            4'h1: seg_lut = 7'b1111001;
            4'h2: seg_lut = 7'b0100100;
            4'h3: seg_lut = 7'b0110000;
            4'h4: seg_lut = 7'b0011001;
            4'h5: seg_lut = 7'b0010010;
            4'h6: seg_lut = 7'b0000010;
            4'h7: seg_lut = 7'b1111000;
            4'h8: seg_lut = 7'b0000000;
            4'h9: seg_lut = 7'b0010000;
            4'hA: seg_lut = 7'b0001000;
            4'hB: seg_lut = 7'b0000011;
            4'hC: seg_lut = 7'b0100111;
            4'hD: seg_lut = 7'b0100001;
            4'hE: seg_lut = 7'b0000110;
            default: seg_lut = 7'b0001110;
        endcase
    endfunction

    assign segIn = seg_lut(nibOut);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        check({tag, "_hex3"}, {25'd0, hex3}, {25'd0, e3});
        check({tag, "_hex2"}, {25'd0, hex2}, {25'd0, e2});
        check({tag, "_hex1"}, {25'd0, hex1}, {25'd0, e1});
        check({tag, "_hex0"}, {25'd0, hex0}, {25'd0, e0});
    endtask

    logic [6:0] cur_hex;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        loadReq  = 1'b0;
        loadData = 32'd0;
        holdPage = 1'b0;
        blank    = 1'b0;

        // ---------------- reset then reset sweep ----------------
        tick(1);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_ack", {31'd0, loadAck}, 32'd0);
        check("rst_page", {31'd0, pageIdx}, 32'd0);
        check_hex("rst", C_OFF, C_OFF, C_OFF, C_OFF);
        tick(1);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            cur_hex = (i == 0) ? hex0 : (i == 1) ? hex1 : (i == 2) ? hex2 : hex3;
            check("sweep_busy", {31'd0, busy}, 32'd1);
            check("sweep_pre", {25'd0, cur_hex}, {25'd0, C_OFF});
            tick(1);
            cur_hex = (i == 0) ? hex0 : (i == 1) ? hex1 : (i == 2) ? hex2 : hex3;
            check("sweep_post", {25'd0, cur_hex}, {25'd0, C_S0});
            check("sweep_ack", {31'd0, loadAck}, 32'd0);
        end
        check("sweep_done_busy", {31'd0, busy}, 32'd0);
        check("idle_nib", {28'd0, nibOut}, 32'd0);
        check("sweep_page", {31'd0, pageIdx}, 32'd0);

        // ---------------- load 1234ABCD ----------------
        loadReq  = 1'b1;
        loadData = 32'h1234ABCD;
        tick(1);
        check("ld_ack", {31'd0, loadAck}, 32'd1);
        check("ld_busy", {31'd0, busy}, 32'd1);
        loadReq = 1'b0;
        tick(1);
        check("ld_ack_once", {31'd0, loadAck}, 32'd0);
        check("ld_hex0_first", {25'd0, hex0}, {25'd0, C_SD});
        tick(3);
        check("ld_busy_end", {31'd0, busy}, 32'd0);
        check_hex("ld", C_SA, C_SB, C_SC, C_SD);

        // ---------------- page flip ----------------
        tick(7);
        check("flip_pre", {31'd0, pageIdx}, 32'd0);
        tick(1);
        check("flip_page", {31'd0, pageIdx}, 32'd1);
        check("flip_busy", {31'd0, busy}, 32'd1);
        tick(4);
        check_hex("flip", C_S1, C_S2, C_S3, C_S4);
        tick(7);
        check("flip2_pre", {31'd0, pageIdx}, 32'd1);
        tick(1);
        check("flip2_page", {31'd0, pageIdx}, 32'd0);
        tick(4);
        check_hex("flip2", C_SA, C_SB, C_SC, C_SD);

        // ---------------- hold mid-count ----------------
        tick(5);
        holdPage = 1'b1;
        tick(20);
        check("hold_page", {31'd0, pageIdx}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd0);
        holdPage = 1'b0;
        tick(2);
        check("hold_rel_pre", {31'd0, pageIdx}, 32'd0);
        tick(1);
        check("hold_rel_flip", {31'd0, pageIdx}, 32'd1);
        tick(4);

        // ---------------- blank ----------------
        blank = 1'b1;
        #1;
        check_hex("blank_a", C_OFF, C_OFF, C_OFF, C_OFF);
        tick(1);
        check_hex("blank_b", C_OFF, C_OFF, C_OFF, C_OFF);
        blank = 1'b0;
        #1;
        check_hex("unblank", C_S1, C_S2, C_S3, C_S4);

        // ---------------- loadReq raised during sweep ----------------
        loadReq  = 1'b1;
        loadData = 32'hCAFE0123;
        tick(1);
        check("col1_ack0", {31'd0, loadAck}, 32'd1);
        loadReq = 1'b0;
        tick(1);
        loadReq  = 1'b1;
        loadData = 32'h55550789;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("col1_no_ack", {31'd0, loadAck}, 32'd0);
        end
        check("col1_idle", {31'd0, busy}, 32'd0);
        tick(1);
        check("col1_ack", {31'd0, loadAck}, 32'd1);
        loadReq = 1'b0;
        tick(4);
        check_hex("col1", C_S0, C_S7, C_S8, C_S9);
        check("col1_page", {31'd0, pageIdx}, 32'd0);

        // ---------------- load coincides with timer expiry ----------------
        tick(7);
        check("col2_pre_page", {31'd0, pageIdx}, 32'd0);
        check("col2_pre_busy", {31'd0, busy}, 32'd0);
        loadReq  = 1'b1;
        loadData = 32'h0000FFFF;
        tick(1);
        check("col2_ack", {31'd0, loadAck}, 32'd1);
        check("col2_page", {31'd0, pageIdx}, 32'd0);
        loadReq = 1'b0;
        tick(4);
        check_hex("col2", C_SF, C_SF, C_SF, C_SF);
        tick(7);
        check("col2_tmr_pre", {31'd0, pageIdx}, 32'd0);
        tick(1);
        check("col2_tmr_flip", {31'd0, pageIdx}, 32'd1);
        tick(4);

        // ---------------- reset mid-sweep ----------------
        loadReq  = 1'b1;
        loadData = 32'h11112222;
        tick(1);
        check("rms_ack", {31'd0, loadAck}, 32'd1);
        loadReq = 1'b0;
        tick(1);
        check("rms_hex0", {25'd0, hex0}, {25'd0, C_S2});
        rst = 1'b1;
        tick(1);
        check("rms_ack0", {31'd0, loadAck}, 32'd0);
        check("rms_busy", {31'd0, busy}, 32'd1);
        check_hex("rms", C_OFF, C_OFF, C_OFF, C_OFF);
        rst = 1'b0;
        #1;
        check("rms_word", {28'd0, nibOut}, 32'd0);
        tick(4);
        check_hex("rms_sweep", C_S0, C_S0, C_S0, C_S0);
        check("rms_page", {31'd0, pageIdx}, 32'd0);
        check("rms_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_page_ctrl.md
Name: hex_page_ctrl

Overview:
- Sequences one shared combinational hex-to-7-segment converter across four registered HEX digit outputs (HEX0..HEX3 on the DE1).
- Holds a 32-bit word loaded by a requester through a req/ack handshake and shows it as two 16-bit pages.
- Pages alternate on a programmable timer.
- Sits between datapath result logic (for example the ALU result) and the board displays.

Parameters:
- PAGE_CYCLES, 50000000, clock cycles a page stays displayed before flipping. Legal range is 2 or more.
- TIMER_W, 26, width of the page timer. It must satisfy 2^TIMER_W > PAGE_CYCLES-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- loadReq  input  1  requester asks to load loadData; held high until loadAck
- loadData  input  32  word to display; sampled only when the load is accepted
- loadAck  output  1  one-cycle pulse: load accepted
- holdPage  input  1  1 = freeze the page timer (page stays put)
- blank  input  1  1 = force all hex outputs to 7'b1111111 (all segments off)
- nibOut  output  4  nibble presented to the shared converter
- segIn  input  7  converter result for nibOut (combinational, same cycle, active-low)
- hex0, hex1, hex2, hex3  output  7 each  active-low segment drive, hex0 = least-significant digit
- pageIdx  output  1  current page: 0 = bits[15:0], 1 = bits[31:16]
- busy  output  1  1 while a digit sweep is in progress

Behaviour:
- Registers: word[31:0], pageIdx, timer[TIMER_W-1:0], digit[1:0], state {IDLE, SWEEP}, loadAck, hex0..3 digit registers.
- Reset (rst=1 at an edge) sets:
  - state=SWEEP, digit=0, word=0, pageIdx=0, timer=0, loadAck=0;
  - hex digit registers=7'b1111111.
  - rst has priority over every other input.
  - Asserting rst mid-sweep or mid-handshake aborts the operation and restarts the reset sweep.
- SWEEP, each cycle:
  - nibOut = word[pageIdx*16 + digit*4 +: 4].
  - At the edge, segIn is written into hex register [digit] and digit increments.
  - On the edge where digit==3, state goes to IDLE and digit returns to 0.
  - A sweep takes exactly 4 cycles.
  - busy=1 throughout SWEEP. The timer is frozen and loadReq is ignored (no ack).
- IDLE:
  - nibOut=0 and busy=0.
  - Priority 1: if loadReq=1, then word<=loadData, pageIdx<=0, timer<=0, loadAck<=1, state<=SWEEP.
  - Priority 2: else if holdPage=0 and timer==PAGE_CYCLES-1, then timer<=0, pageIdx<=~pageIdx, state<=SWEEP.
  - Priority 3: else if holdPage=0, timer<=timer+1.
  - Otherwise (holdPage=1), timer holds.
- Simultaneous load and timer expiry in IDLE: load wins, page becomes 0 and the timer is cleared.
- loadAck is registered, so it is high exactly one cycle: the first SWEEP cycle after acceptance. The requester must drop loadReq after seeing the ack.
- If loadReq stays high, a new load is accepted on the first IDLE edge. That is the edge after the sweep completes, giving an accept every 5 cycles minimum.
- Load latency from the accepting edge E0:
  - loadAck=1 and busy=1 in the cycle after E0.
  - hex0 is updated at E0+1, hex3 at E0+4, and IDLE resumes after E0+4.
- Hex outputs equal the hex digit registers when blank=0 and are forced to 7'b1111111 when blank=1.
  - blank is combinational and does not touch the registers or stall the sweep.
- Digits update one per cycle during a sweep. A mixed old/new display for up to 3 cycles is acceptable.
- Page flip period with holdPage=0 and no loads: PAGE_CYCLES IDLE cycles plus 4 sweep cycles.
- Timer wrap: the timer never exceeds PAGE_CYCLES-1. Toggling holdPage preserves the partially counted value.

Test Plan:
- Reset, then sweep:
  - Stimulus: assert rst for 2 cycles, then release; converter model attached.
  - Required: busy=1 for 4 cycles, hex0..3=7'b1111111 until each digit is written, then all hex0..3=7'b1000000 ("0"), pageIdx=0, loadAck never high.
- Load 32'h1234ABCD in IDLE:
  - Required: loadAck high exactly 1 cycle.
  - 4 cycles later: hex3..hex0 = 0001000 (A), 0000011 (b), 0100111 (c), 0100001 (d).
- Page flip:
  - Stimulus: PAGE_CYCLES=8, no load, holdPage=0, after the above load.
  - Required: after 8 IDLE cycles, pageIdx=1, then hex3..hex0 = 1111001 (1), 0100100 (2), 0110000 (3), 0011001 (4).
  - 12 cycles later: page 0 again.
- Hold and blank:
  - Stimulus: holdPage=1 for 20 cycles mid-count (timer=5).
  - Required: pageIdx unchanged; after release, the flip occurs 3 cycles later.
  - Stimulus: blank=1 for 2 cycles.
  - Required: all hex outputs 7'b1111111, restored digits unchanged afterwards.
- Collisions:
  - Stimulus: loadReq rises during SWEEP.
  - Required: no ack until the first IDLE edge.
  - Stimulus: loadReq=1 (loadData=32'h0000FFFF) on the same edge the timer hits 7.
  - Required: load wins, pageIdx=0, hex3..0=0001110 (F) ×4, timer restarts at 0.
- Reset mid-sweep:
  - Stimulus: rst at the second SWEEP cycle of a load.
  - Required: loadAck=0, word=0, hex registers all 7'b1111111, then the reset sweep shows "0000".
